param_rob: RTL

//  Parametrised reorder buffer for the Tomasulo core. Circular queue of in-flight instructions.
//  - Allocated in order by issue control.
//  - Completed out of order by N_CDB result buses.
//  - Retired in order to write-results control.
//  Two operand read ports let issue control fetch ready values. Full flush supports mispredict recovery.

---
 rtl/param_rob.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/param_rob.sv
// param_rob: parametrised reorder buffer, in-order allocate/retire with out-of-order CDB completion.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB results to the read and commit ports.
module param_rob #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int N_CDB = 2,
  parameter int OPW   = 4,
  parameter int REGW  = 3,
  localparam int TAGW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   alloc_valid,
  input  logic [OPW-1:0]         alloc_opcode,
  input  logic [REGW-1:0]        alloc_dest,
  input  logic [WIDTH-1:0]       alloc_value,
  input  logic                   alloc_ready,
  input  logic                   alloc_predict,
  output logic [TAGW-1:0]        alloc_tag,
  output logic                   full,
  output logic                   empty,
  output logic [TAGW:0]          count,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*TAGW-1:0]  cdb_tag,
  input  logic [N_CDB*WIDTH-1:0] cdb_value,
  input  logic [TAGW-1:0]        sr1_tag,
  input  logic [TAGW-1:0]        sr2_tag,
  output logic [WIDTH-1:0]       sr1_value,
  output logic [WIDTH-1:0]       sr2_value,
  output logic                   sr1_valid,
  output logic                   sr2_valid,
  output logic                   commit_valid,
  output logic [OPW-1:0]         commit_opcode,
  output logic [REGW-1:0]        commit_dest,
  output logic [WIDTH-1:0]       commit_value,
  output logic                   commit_predict,
  input  logic                   commit_ack
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_pred;
  logic [OPW-1:0]   r_op   [DEPTH];
  logic [REGW-1:0]  r_dest [DEPTH];
  logic [WIDTH-1:0] r_val  [DEPTH];
  logic [TAGW-1:0]  r_head;
  logic [TAGW-1:0]  r_tail;
  logic [TAGW:0]    r_count;

  logic [DEPTH-1:0] w_cdb_any;
  logic [DEPTH-1:0] w_cdb_hit;
  logic [WIDTH-1:0] w_cdb_val  [DEPTH];
  logic [DEPTH-1:0] w_byp;
  logic [DEPTH-1:0] w_view_ready;
  logic [WIDTH-1:0] w_view_val [DEPTH];
  logic             w_alloc;
  logic             w_commit;

  function automatic logic [TAGW-1:0] ptr_next(input logic [TAGW-1:0] p);
    if (p == TAGW'(DEPTH - 1)) begin
      ptr_next = {TAGW{1'b0}};
    end else begin
      ptr_next = p + TAGW'(1);
    end
  endfunction

  // Resolve CDB broadcasts per entry; buses are scanned high to low so the lowest index wins
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_cdb_any[e] = 1'b0;
      w_cdb_val[e] = {WIDTH{1'b0}};
      for (int i = N_CDB - 1; i >= 0; i--) begin
        w_cdb_any[e] = w_cdb_any[e] |
                       (cdb_valid[i] & (cdb_tag[i*TAGW +: TAGW] == TAGW'(e)));
        w_cdb_val[e] = (cdb_valid[i] && (cdb_tag[i*TAGW +: TAGW] == TAGW'(e)))
                       ? cdb_value[i*WIDTH +: WIDTH] : w_cdb_val[e];
      end
      // Only a busy, still-waiting entry accepts a result
      w_cdb_hit[e] = w_cdb_any[e] & r_busy[e] & ~r_ready[e];
    end
  end

`ifdef ROB_CDB_BYPASS_EN
  assign w_byp = w_cdb_hit;
`else
  assign w_byp = {DEPTH{1'b0}};
`endif

  // Per-entry view seen by the read and commit ports (bypass folded in when enabled)
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_view_ready[e] = r_ready[e] | w_byp[e];
      w_view_val[e]   = w_byp[e] ? w_cdb_val[e] : r_val[e];
    end
  end

  // Operand read ports as AND-OR muxes so an out-of-range tag reads as empty
  always_comb begin
    sr1_valid = 1'b0;
    sr1_value = {WIDTH{1'b0}};
    sr2_valid = 1'b0;
    sr2_value = {WIDTH{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      sr1_valid = sr1_valid | ((sr1_tag == TAGW'(e)) & r_busy[e] & w_view_ready[e]);
      sr1_value = sr1_value | ({WIDTH{(sr1_tag == TAGW'(e)) & r_busy[e]}} & w_view_val[e]);
      sr2_valid = sr2_valid | ((sr2_tag == TAGW'(e)) & r_busy[e] & w_view_ready[e]);
      sr2_value = sr2_value | ({WIDTH{(sr2_tag == TAGW'(e)) & r_busy[e]}} & w_view_val[e]);
    end
  end

  // Head entry presented for retirement
  always_comb begin
    commit_valid   = r_busy[r_head] & w_view_ready[r_head];
    commit_opcode  = r_op[r_head];
    commit_dest    = r_dest[r_head];
    commit_value   = w_view_val[r_head];
    commit_predict = r_pred[r_head];
  end

  assign w_alloc   = alloc_valid & ~full;
  assign w_commit  = commit_ack & commit_valid;
  assign full      = (r_count == (TAGW+1)'(DEPTH));
  assign empty     = (r_count == {(TAGW+1){1'b0}});
  assign count     = r_count;
  assign alloc_tag = r_tail;

  // Entry array, pointers and occupancy; flush outranks every same-cycle operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_busy[e]  <= 1'b0;
        r_ready[e] <= 1'b0;
        r_pred[e]  <= 1'b0;
        r_op[e]    <= {OPW{1'b0}};
        r_dest[e]  <= {REGW{1'b0}};
        r_val[e]   <= {WIDTH{1'b0}};
      end
      r_head  <= {TAGW{1'b0}};
      r_tail  <= {TAGW{1'b0}};
      r_count <= {(TAGW+1){1'b0}};
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_busy[e]  <= 1'b0;
        r_ready[e] <= 1'b0;
        r_pred[e]  <= 1'b0;
        r_op[e]    <= {OPW{1'b0}};
        r_dest[e]  <= {REGW{1'b0}};
        r_val[e]   <= {WIDTH{1'b0}};
      end
      r_head  <= {TAGW{1'b0}};
      r_tail  <= {TAGW{1'b0}};
      r_count <= {(TAGW+1){1'b0}};
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_commit && (r_head == TAGW'(e))) begin
          r_busy[e]  <= 1'b0;
          r_ready[e] <= 1'b0;
          r_pred[e]  <= 1'b0;
          r_op[e]    <= {OPW{1'b0}};
          r_dest[e]  <= {REGW{1'b0}};
          r_val[e]   <= {WIDTH{1'b0}};
        end else if (w_alloc && (r_tail == TAGW'(e))) begin
          r_busy[e]  <= 1'b1;
          r_ready[e] <= alloc_ready;
          r_pred[e]  <= alloc_predict;
          r_op[e]    <= alloc_opcode;
          r_dest[e]  <= alloc_dest;
          r_val[e]   <= alloc_value;
        end else if (w_cdb_hit[e]) begin
          r_ready[e] <= 1'b1;
          r_val[e]   <= w_cdb_val[e];
        end else begin
          r_ready[e] <= r_ready[e];
        end
      end
      if (w_alloc) begin
        r_tail <= ptr_next(r_tail);
      end else begin
        r_tail <= r_tail;
      end
      if (w_commit) begin
        r_head <= ptr_next(r_head);
      end else begin
        r_head <= r_head;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + (TAGW+1)'(1);
        2'b01:   r_count <= r_count - (TAGW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
